// File: rtl/exec_pkg.sv
// Shared definitions for the execution engine: opcodes, instruction layout,
// bus unit selects and the instruction-fetch state encoding.
package exec_pkg;

    localparam logic [7:0] OP_MMULT      = 8'h00;
    localparam logic [7:0] OP_MADD       = 8'h01;
    localparam logic [7:0] OP_MSUB       = 8'h02;
    localparam logic [7:0] OP_MTRANSPOSE = 8'h03;
    localparam logic [7:0] OP_MSCALE     = 8'h04;
    localparam logic [7:0] OP_MSCALEIMM  = 8'h05;
    localparam logic [7:0] OP_INTADD     = 8'h10;
    localparam logic [7:0] OP_INTSUB     = 8'h11;
    localparam logic [7:0] OP_INTMULT    = 8'h12;
    localparam logic [7:0] OP_INTDIV     = 8'h13;
    localparam logic [7:0] OP_STOP       = 8'hFF;

    // Unit selects driven on address[15:12]
    localparam logic [3:0] NONE_SELECT   = 4'b0000;
    localparam logic [3:0] INSTR_SELECT  = 4'b1000;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch bus initiator: reads one 32-bit word per instruction from
// instruction memory and hands decoded fields to the execution engine.
//
// state   | meaning
// IDLE    | waiting for Start, bus parked at 0
// REQ     | read strobe low, memory registers the word at pc
// WAIT    | word available on DataIn, captured at the closing edge
// PRESENT | instruction valid, held until InstrReady
// DONE    | Stop opcode fetched, halted until next Start
module instruction_fetch
    import exec_pkg::*;
(
    input  logic         Clk,
    input  logic         nReset,
    input  logic         Start,
    input  logic [11:0]  StartPC,
    output logic [15:0]  address,
    output logic         nRead,
    input  logic [255:0] DataIn,
    output logic         InstrValid,
    input  logic         InstrReady,
    output logic [7:0]   Opcode,
    output logic [7:0]   Dest,
    output logic [7:0]   Src1,
    output logic [7:0]   Src2,
    output logic [11:0]  PC,
    output logic         Busy,
    output logic         Halted
);

    fetch_state_t r_state;
    logic [11:0]  r_pc;
    instr_t       r_instr;
    logic         r_nread;
    logic [15:0]  r_addr;

    fetch_state_t w_next_state;
    logic [11:0]  w_pc_next;
    instr_t       w_instr_next;
    instr_t       w_data_word;
    logic         w_nread_next;
    logic [15:0]  w_addr_next;
    logic         w_unused_data;

    assign w_data_word   = instr_t'(DataIn[31:0]);
    assign w_unused_data = ^DataIn[255:32];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_pc    <= 12'h000;
            r_instr <= '0;
            r_nread <= 1'b1;
            r_addr  <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_nread <= w_nread_next;
            r_addr  <= w_addr_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    w_next_state = S_REQ;
                    w_pc_next    = StartPC;
                end
            end
            S_REQ: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_instr_next = w_data_word;
                // The Stop word halts the engine without ever being presented
                if (w_data_word.opcode == OP_STOP) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (InstrReady) begin
                    w_next_state = S_REQ;
                    w_pc_next    = r_pc + 12'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Bus outputs are computed from the next state so they come straight off flops
    always_comb begin
        w_nread_next = 1'b1;
        w_addr_next  = {NONE_SELECT, 12'h000};
        InstrValid   = 1'b0;
        Busy         = 1'b0;
        Halted       = 1'b0;
        if (w_next_state == S_REQ) begin
            w_nread_next = 1'b0;
        end
        if (w_next_state == S_REQ || w_next_state == S_WAIT || w_next_state == S_PRESENT) begin
            w_addr_next = {INSTR_SELECT, w_pc_next};
        end
        unique case (r_state)
            S_REQ, S_WAIT: Busy = 1'b1;
            S_PRESENT: begin
                Busy       = 1'b1;
                InstrValid = 1'b1;
            end
            S_DONE:  Halted = 1'b1;
            default: ;
        endcase
    end

    assign address = r_addr;
    assign nRead   = r_nread;
    assign Opcode  = r_instr.opcode;
    assign Dest    = r_instr.dest;
    assign Src1    = r_instr.src1;
    assign Src2    = r_instr.src2;
    assign PC      = r_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a registered instruction-memory model
// and a bus monitor recording every read strobe.
module tb_instruction_fetch;

    logic         Clk = 1'b0;
    logic         nReset;
    logic         Start;
    logic [11:0]  StartPC;
    logic [15:0]  address;
    logic         nRead;
    logic [255:0] DataIn;
    logic         InstrValid;
    logic         InstrReady;
    logic [7:0]   Opcode, Dest, Src1, Src2;
    logic [11:0]  PC;
    logic         Busy;
    logic         Halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] r_data;
    logic [15:0] pulse_addr [$];
    int          consec_low = 0;
    logic        prev_low = 1'b0;

    always #5 Clk = ~Clk;

    instruction_fetch dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .StartPC(StartPC),
        .address(address), .nRead(nRead), .DataIn(DataIn),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Opcode(Opcode), .Dest(Dest), .Src1(Src1), .Src2(Src2),
        .PC(PC), .Busy(Busy), .Halted(Halted)
    );

    always @(posedge Clk) begin
        if (!nRead) r_data <= mem[address[11:0]];
    end
    assign DataIn = {{224{1'b1}}, r_data};

    always @(negedge Clk) begin
        if (nReset && !nRead) begin
            pulse_addr.push_back(address);
            if (prev_low) consec_low++;
        end
        prev_low = nReset && !nRead;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0000;
        mem[0]       = 32'h01_02_00_01;
        mem[1]       = 32'h02_03_00_01;
        mem[2]       = 32'hFF_FF_FF_FF;
        mem[3]       = 32'h10_11_12_13;
        mem[4]       = 32'hFF_00_00_00;
        mem[12'hFFF] = 32'h04_05_06_07;
        r_data = 32'h0;

        nReset = 1'b0; Start = 1'b0; StartPC = 12'h000; InstrReady = 1'b1;
        #12;
        chk("rst_address", address, 16'h0000);
        chk("rst_nRead", nRead, 1);
        chk("rst_valid", InstrValid, 0);
        chk("rst_fields", {Opcode, Dest, Src1, Src2}, 32'h0);
        chk("rst_pc", PC, 0);
        chk("rst_busy_halted", {Busy, Halted}, 0);
        tick();
        nReset = 1'b1;
        tick();

        // Basic run: two instructions then Stop, ready tied high
        Start = 1'b1; StartPC = 12'h000;
        tick(); Start = 1'b0;
        chk("t1_req0_nread", nRead, 0);
        chk("t1_req0_addr", address, 16'h8000);
        chk("t1_req0_busy", Busy, 1);
        tick();
        chk("t1_wait0_nread", nRead, 1);
        chk("t1_wait0_valid", InstrValid, 0);
        tick();
        chk("t1_pres0_valid", InstrValid, 1);
        chk("t1_pres0_op_dest", {Opcode, Dest}, 16'h0102);
        chk("t1_pres0_pc", PC, 12'h000);
        tick();
        chk("t1_req1_valid", InstrValid, 0);
        chk("t1_req1_addr", address, 16'h8001);
        tick(); tick();
        chk("t1_pres1_op_dest", {Opcode, Dest}, 16'h0203);
        chk("t1_pres1_pc", PC, 12'h001);
        tick();
        chk("t1_req2_addr", address, 16'h8002);
        tick(); tick();
        chk("t1_done_halted", Halted, 1);
        chk("t1_done_busy", Busy, 0);
        chk("t1_done_valid", InstrValid, 0);
        chk("t1_done_addr", address, 16'h0000);
        tick(); tick();
        chk("t1_pulse_count", pulse_addr.size(), 3);
        if (pulse_addr.size() == 3) begin
            chk("t1_pulse_a0", pulse_addr[0], 16'h8000);
            chk("t1_pulse_a1", pulse_addr[1], 16'h8001);
            chk("t1_pulse_a2", pulse_addr[2], 16'h8002);
        end
        pulse_addr.delete();

        // Wrap, backpressure and Start ignored in REQ/PRESENT
        InstrReady = 1'b0;
        Start = 1'b1; StartPC = 12'hFFF;
        tick();
        chk("t2_req_addr", address, 16'h8FFF);
        StartPC = 12'h005;
        tick(); Start = 1'b0;
        chk("t2_wait_busy", Busy, 1);
        tick();
        chk("t2_pres_fields", {Opcode, Dest, Src1, Src2}, 32'h04050607);
        chk("t2_pres_pc", PC, 12'hFFF);
        pulse_addr.delete();
        for (int i = 0; i < 5; i++) begin
            Start = (i == 2);
            tick();
            chk("t2_bp_valid", InstrValid, 1);
            chk("t2_bp_fields", {Opcode, Dest, Src1, Src2}, 32'h04050607);
            chk("t2_bp_nread", nRead, 1);
        end
        Start = 1'b0;
        chk("t2_bp_no_pulse", pulse_addr.size(), 0);
        InstrReady = 1'b1;
        tick(); InstrReady = 1'b0;
        chk("t2_wrap_addr", address, 16'h8000);
        chk("t2_wrap_nread", nRead, 0);
        chk("t2_wrap_valid", InstrValid, 0);
        chk("t2_wrap_pc", PC, 12'h000);
        tick(); tick();
        chk("t2_pres_op", Opcode, 8'h01);
        chk("t2_pres_pc0", PC, 12'h000);

        // Reset asserted during WAIT, then restart at 3
        InstrReady = 1'b1;
        tick(); InstrReady = 1'b0;
        chk("t3_req_addr", address, 16'h8001);
        tick();
        chk("t3_in_wait", {Busy, InstrValid, nRead}, 3'b101);
        nReset = 1'b0;
        #1;
        chk("t3_rst_address", address, 16'h0000);
        chk("t3_rst_nread", nRead, 1);
        chk("t3_rst_valid", InstrValid, 0);
        chk("t3_rst_fields", {Opcode, Dest, Src1, Src2}, 32'h0);
        chk("t3_rst_pc", PC, 0);
        chk("t3_rst_busy_halted", {Busy, Halted}, 0);
        tick();
        nReset = 1'b1;
        tick(); tick();
        chk("t3_stays_idle", {Busy, nRead}, 2'b01);
        Start = 1'b1; StartPC = 12'h003;
        tick(); Start = 1'b0;
        chk("t3_refetch_addr", address, 16'h8003);
        chk("t3_refetch_nread", nRead, 0);
        tick(); tick();
        chk("t3_pres_fields", {Opcode, Dest, Src1, Src2}, 32'h10111213);
        chk("t3_pres_pc", PC, 12'h003);
        InstrReady = 1'b1;
        tick();
        chk("t3_req4_addr", address, 16'h8004);
        tick(); tick();
        chk("t3_done_halted", Halted, 1);

        // Start in DONE restarts at the new StartPC
        Start = 1'b1; StartPC = 12'h001; InstrReady = 1'b0;
        tick(); Start = 1'b0;
        chk("t4_halted_clear", Halted, 0);
        chk("t4_busy", Busy, 1);
        chk("t4_addr", address, 16'h8001);
        chk("t4_nread", nRead, 0);
        tick(); tick();
        chk("t4_pres_op_dest", {Opcode, Dest}, 16'h0203);
        chk("t4_pres_pc", PC, 12'h001);

        chk("nread_never_consecutive", consec_low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Bus initiator inside the execution engine that fetches 32-bit instructions from the instruction memory over the shared address/nRead/data bus. It sequences the program counter and presents each decoded instruction (opcode, dest, src1, src2) to the execution engine through a valid/ready handshake. It halts on the Stop opcode (FFh).

## Interface
- INSTR_SELECT, 4'b1000, value driven on address[15:12] to select instruction memory
- Clk  input  1  system clock; all state on posedge
- nReset  input  1  asynchronous, active-low reset
- Start  input  1  single-cycle pulse; begins fetching at StartPC
- StartPC  input  12  first instruction word address
- address  output  16  bus address: {INSTR_SELECT, pc} while fetching, else 16'h0000
- nRead  output  1  active-low read strobe to instruction memory
- DataIn  input  256  instruction memory read data; instruction in [31:0], [255:32] ignored
- InstrValid  output  1  Opcode/Dest/Src1/Src2/PC hold a valid instruction
- InstrReady  input  1  execution engine accepts the presented instruction
- Opcode, Dest, Src1, Src2  output  8 each  DataIn[31:24], [23:16], [15:8], [7:0] of the captured word
- PC  output  12  word address of the presented instruction
- Busy  output  1  high in REQ, WAIT, PRESENT
- Halted  output  1  high in DONE (Stop fetched)

## Operation
- States: IDLE, REQ, WAIT, PRESENT, DONE.
- IDLE: nRead=1, address=0. Start=1 loads pc<=StartPC and moves to REQ.
- REQ (one cycle): nRead=0, address={INSTR_SELECT,pc}. Memory registers the word on the closing edge. Next state is WAIT.
- WAIT (one cycle): nRead=1, address held. On the closing edge, DataIn[31:0] is captured into the instruction register.
  - Captured opcode FFh: go to DONE. The Stop word is never presented.
  - Otherwise: go to PRESENT.
- PRESENT: InstrValid=1; fields and PC stable. nRead=1, address held.
  - InstrReady=1 at an edge: pc<=pc+1 and go to REQ.
  - InstrReady=0: remain in PRESENT indefinitely.
- DONE: Halted=1, nRead=1, address=0. Start=1 clears Halted, loads StartPC and goes to REQ.
- Start is ignored in REQ, WAIT and PRESENT.
- pc increment is modulo 4096: 12'hFFF wraps to 12'h000 with no flag.
- Opcode values are not interpreted except FFh. Unknown opcodes are presented unchanged.
- nRead is registered and glitch-free. It is never low for more than one consecutive cycle.

## Timing
- Reset values, applied asynchronously on nReset low:
  - address=16'h0000, nRead=1
  - InstrValid=0, Opcode=Dest=Src1=Src2=0, PC=0
  - Busy=0, Halted=0
  - state=IDLE
- Reset asserted mid-fetch (any state) forces the reset values immediately. Fetching resumes only after a new Start.
- Start sampled at edge t: nRead low in cycle t+1 (REQ), WAIT in t+2, InstrValid high in cycle t+3.
- Minimum throughput is 3 cycles per instruction, with InstrReady held high.
- InstrValid drops in the cycle after acceptance. It never toggles while PRESENT waits.
- Stop fetched: Halted rises in the cycle after WAIT, and Busy falls in that same cycle.

## Structure
- Shared package exec_pkg holds:
  - opcode constants: OP_MMULT 00h, OP_MADD 01h, OP_MSUB 02h, OP_MTRANSPOSE 03h, OP_MSCALE 04h, OP_MSCALEIMM 05h, OP_INTADD 10h, OP_INTSUB 11h, OP_INTMULT 12h, OP_INTDIV 13h, OP_STOP FFh
  - packed struct instr_t {opcode, dest, src1, src2}
  - unit-select constants for address[15:12]
  - fetch state enum
- Single module, no sub-module. Field extraction is a cast of the captured word to instr_t.

## Test plan
- Reset, then Start with StartPC=0 against memory holding 01_02_00_01, 02_03_00_01, FF_FF_FF_FF, with InstrReady tied high:
  - two instructions presented: Opcode 01h/Dest 02h at PC 0, then Opcode 02h/Dest 03h at PC 1
  - Halted rises; only three nRead pulses, each at address 16'h8000, 16'h8001, 16'h8002 respectively.
- Backpressure: hold InstrReady=0 for 5 cycles while PRESENT:
  - InstrValid and fields stay constant
  - no nRead pulse occurs
  - next fetch follows acceptance by exactly one cycle.
- Wrap: StartPC=12'hFFF, non-stop word at FFFh → after acceptance, next address is 16'h8000.
- Start pulsed during REQ and during PRESENT → ignored; PC sequence unchanged.
- Reset asserted during WAIT → all outputs return to reset values that cycle. A new Start at StartPC=3 refetches from 16'h8003.
- Start in DONE → Halted clears next cycle and fetching restarts at the new StartPC.
